// File: rtl/count_slot_scheduler.sv
// Round-robin owner of a single tick counter shared by two requesters.
// A granted requester gets len ticks (0 means 2**WIDTH), then a one-cycle done pulse.
module count_slot_scheduler #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_,
    input  logic             req0,
    input  logic [WIDTH-1:0] len0,
    input  logic             req1,
    input  logic [WIDTH-1:0] len1,
    input  logic             tick,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             busy,
    output logic [WIDTH-1:0] cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic             owner, owner_nx;   // which requester holds the slot
    logic             ptr, ptr_nx;       // last served requester
    logic             gnt, gnt_nx;
    logic             done, done_nx;
    logic [WIDTH-1:0] target, target_nx;
    logic [WIDTH-1:0] cnt_nx;

    logic own_req;
    logic pick1;
    logic terminal;

    // Terminal compare is modulo 2**WIDTH, so target=0 runs a full wrap.
    always_comb begin
        own_req  = owner ? req1 : req0;
        pick1    = req1 && (!req0 || !ptr);
        terminal = (cnt == (target - WIDTH'(1)));
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state  <= IDLE;
            owner  <= 1'b0;
            ptr    <= 1'b1;
            gnt    <= 1'b0;
            done   <= 1'b0;
            target <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nx;
            owner  <= owner_nx;
            ptr    <= ptr_nx;
            gnt    <= gnt_nx;
            done   <= done_nx;
            target <= target_nx;
            cnt    <= cnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        owner_nx  = owner;
        ptr_nx    = ptr;
        gnt_nx    = gnt;
        done_nx   = 1'b0;
        target_nx = target;
        cnt_nx    = cnt;
        unique case (state)
            IDLE: begin
                gnt_nx = 1'b0;
                if (req0 || req1) begin
                    owner_nx  = pick1;
                    gnt_nx    = 1'b1;
                    target_nx = pick1 ? len1 : len0;
                    cnt_nx    = '0;
                    state_nx  = RUN;
                end
            end
            RUN: begin
                // Abort wins over a terminal tick in the same cycle.
                if (!own_req) begin
                    state_nx = IDLE;
                    gnt_nx   = 1'b0;
                    ptr_nx   = owner;
                    cnt_nx   = '0;
                end else if (tick) begin
                    cnt_nx = cnt + WIDTH'(1);
                    if (terminal) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
                gnt_nx   = 1'b0;
                ptr_nx   = owner;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = 1'b0;
                cnt_nx   = '0;
            end
        endcase
    end

    assign gnt0  = gnt & ~owner;
    assign gnt1  = gnt & owner;
    assign done0 = done & ~owner;
    assign done1 = done & owner;
    assign busy  = (state != IDLE);

endmodule
